// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared types and encodings for the FP op sequencer.
//   seq_state_t      - sequencer FSM states
//   FRM_*            - RISC-V rounding-mode encodings (101/110 reserved)
//   FFLAG_*          - bit positions inside the 5-bit fflags vector
//   resolve_frm()    - instruction frm, or fcsr.frm when the instruction says dynamic
//   frm_is_reserved()- true for encodings the FPU must never see
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } seq_state_t;

    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;
    localparam logic [2:0] FRM_DYN = 3'b111;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    function automatic logic [2:0] resolve_frm(input logic [2:0] inst_frm,
                                               input logic [2:0] csr_frm);
        return (inst_frm == FRM_DYN) ? csr_frm : inst_frm;
    endfunction

    // Anything above RMM is reserved once resolved (including DYN held in fcsr).
    function automatic logic frm_is_reserved(input logic [2:0] frm);
        return frm > FRM_RMM;
    endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: accepts one FP operation at a time, launches the FPU,
// waits for its result (with a timeout), and writes the result back to the
// FP register file. FLW load write-backs share the write port and always win.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_rd/rs1/rs2, req_frm   operation fields; fcsr_frm used when req_frm = DYN
//   rf_rs1, rf_rs2            register-file read indices for the running op
//   fpu_start, fpu_frm        one-cycle launch pulse and resolved rounding mode
//   fpu_done/result/flags     FPU completion
//   ld_wen/ld_rd/ld_data      FLW write-back request
//   rf_wen/rf_rd/rf_w_data    register-file write port
//   fflags_set                accrued-flag pulse on result commit
//   illegal_rm, timeout       one-cycle error pulses
//   busy                      high whenever not IDLE
module fpu_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_frm,
    input  logic [2:0]  fcsr_frm,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    output logic        fpu_start,
    output logic [2:0]  fpu_frm,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    input  logic        ld_wen,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        rf_wen,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_w_data,
    output logic [4:0]  fflags_set,
    output logic        illegal_rm,
    output logic        timeout,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    seq_state_t  state_reg,   state_next;
    logic [4:0]  rd_reg,      rd_next;
    logic [4:0]  rs1_reg,     rs1_next;
    logic [4:0]  rs2_reg,     rs2_next;
    logic [2:0]  frm_reg,     frm_next;
    logic [31:0] result_reg,  result_next;
    logic [4:0]  flags_reg,   flags_next;
    logic [7:0]  cnt_reg,     cnt_next;
    logic        illegal_reg, illegal_next;
    logic        timeout_reg, timeout_next;

    logic [2:0]  frm_resolved;
    logic        accept;
    logic        run;
    logic        in_op;
    logic        commit;

    assign frm_resolved = resolve_frm(req_frm, fcsr_frm);
    assign accept       = req_valid && (state_reg == ST_IDLE);

    always_comb begin
        state_next   = state_reg;
        rd_next      = rd_reg;
        rs1_next     = rs1_reg;
        rs2_next     = rs2_reg;
        frm_next     = frm_reg;
        result_next  = result_reg;
        flags_next   = flags_reg;
        cnt_next     = cnt_reg;
        illegal_next = 1'b0;
        timeout_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    rd_next  = req_rd;
                    rs1_next = req_rs1;
                    rs2_next = req_rs2;
                    frm_next = frm_resolved;
                    if (frm_is_reserved(frm_resolved)) begin
                        illegal_next = 1'b1;
                    end else begin
                        state_next = ST_START;
                    end
                end
            end
            ST_START: begin
                if (fpu_done) begin
                    result_next = fpu_result;
                    flags_next  = fpu_flags;
                    state_next  = ST_WB;
                end else begin
                    cnt_next   = 8'd0;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (fpu_done) begin
                    result_next = fpu_result;
                    flags_next  = fpu_flags;
                    state_next  = ST_WB;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    // cnt_next counts EXEC cycles spent without a result.
                    if (cnt_next == TIMEOUT_LIMIT) begin
                        timeout_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
            end
            ST_WB: begin
                // A load holding the write port stalls the commit in place.
                if (!ld_wen) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rd_reg      <= 5'd0;
            rs1_reg     <= 5'd0;
            rs2_reg     <= 5'd0;
            frm_reg     <= 3'd0;
            result_reg  <= 32'd0;
            flags_reg   <= 5'd0;
            cnt_reg     <= 8'd0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_reg      <= rd_next;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            frm_reg     <= frm_next;
            result_reg  <= result_next;
            flags_reg   <= flags_next;
            cnt_reg     <= cnt_next;
            illegal_reg <= illegal_next;
            timeout_reg <= timeout_next;
        end
    end

    // Every output is forced quiet while rst is high, so an op interrupted
    // by reset can never leak a write, flag pulse or error pulse.
    assign run    = !rst;
    assign in_op  = (state_reg != ST_IDLE);
    assign commit = run && (state_reg == ST_WB) && !ld_wen;

    assign req_ready  = run && !in_op;
    assign busy       = run && in_op;
    assign fpu_start  = run && (state_reg == ST_START);
    assign rf_rs1     = busy ? rs1_reg : 5'd0;
    assign rf_rs2     = busy ? rs2_reg : 5'd0;
    assign fpu_frm    = busy ? frm_reg : 3'd0;
    assign illegal_rm = run && illegal_reg;
    assign timeout    = run && timeout_reg;
    assign fflags_set = commit ? flags_reg : 5'd0;

    // Write port: FLW first, then the FSM commit.
    always_comb begin
        rf_wen    = 1'b0;
        rf_rd     = 5'd0;
        rf_w_data = 32'd0;
        if (run && ld_wen) begin
            rf_wen    = 1'b1;
            rf_rd     = ld_rd;
            rf_w_data = ld_data;
        end else if (commit) begin
            rf_wen    = 1'b1;
            rf_rd     = rd_reg;
            rf_w_data = result_reg;
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: directed and randomized checks of fpu_sequencer.
// Each operation is described by its fields, the cycle its FPU result
// arrives and a window of FLW writes; the expected outputs for every cycle
// are derived from those event times.
module tb_fpu_sequencer;
    import fpu_seq_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [2:0]  req_frm = '0, fcsr_frm = '0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic        fpu_start;
    logic [2:0]  fpu_frm;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;
    logic [4:0]  fpu_flags = '0;
    logic        ld_wen = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_w_data;
    logic [4:0]  fflags_set;
    logic        illegal_rm, timeout, busy;

    always #5 clk = ~clk;

    fpu_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_frm(req_frm), .fcsr_frm(fcsr_frm),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .fpu_start(fpu_start), .fpu_frm(fpu_frm),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .ld_wen(ld_wen), .ld_rd(ld_rd), .ld_data(ld_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
        .fflags_set(fflags_set), .illegal_rm(illegal_rm),
        .timeout(timeout), .busy(busy)
    );

    // {req_ready, fpu_start, fpu_frm, rf_rs1, rf_rs2, rf_wen, rf_rd,
    //  rf_w_data, fflags_set, illegal_rm, timeout, busy}
    logic [60:0] obs;
    assign obs = {req_ready, fpu_start, fpu_frm, rf_rs1, rf_rs2, rf_wen, rf_rd,
                  rf_w_data, fflags_set, illegal_rm, timeout, busy};

    localparam logic [60:0] IDLE_VEC  = {1'b1, 60'd0};
    localparam logic [60:0] QUIET_VEC = 61'd0;

    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  frm, fcsr;
        int          d;        // result arrives d cycles after the start cycle; <0 = never
        logic [31:0] result;
        logic [4:0]  flags;
        int          ld_s, ld_n;
        logic [4:0]  ld_rd;
        logic [31:0] ld_data;
        bit          stray;    // extra fpu_done pulses where they must be ignored
    } op_t;

    op_t op;
    int  checks = 0;
    int  passes = 0;

    // ---------------- reference model (cycle 0 = acceptance) ----------------
    function automatic bit in_ld(int c);
        return (c >= op.ld_s) && (c < op.ld_s + op.ld_n);
    endfunction

    function automatic logic [2:0] res_frm();
        return (op.frm == 3'b111) ? op.fcsr : op.frm;
    endfunction

    function automatic bit legal();
        return res_frm() < 3'd5;
    endfunction

    function automatic bit times_out();
        return legal() && (op.d < 0 || op.d > T);
    endfunction

    // Earliest cycle after the result is captured in which no load holds the port.
    function automatic int write_cycle();
        if (!legal() || times_out()) return -1;
        for (int k = 2 + op.d; k < 1000; k++)
            if (!in_ld(k)) return k;
        return -1;
    endfunction

    function automatic int last_cycle();
        int l;
        l = 1;
        if (write_cycle() > l) l = write_cycle();
        if (times_out() && T + 2 > l) l = T + 2;
        if (op.ld_n > 0 && op.ld_s + op.ld_n - 1 > l) l = op.ld_s + op.ld_n - 1;
        if (op.d >= 0 && 1 + op.d > l) l = 1 + op.d;
        return l + 1;
    endfunction

    function automatic logic [60:0] model_out(int c);
        logic [2:0]  r;
        bit          lg, to, bz, ld, cm;
        int          wc, be;
        logic [4:0]  wrd;
        logic [31:0] wd;
        r  = res_frm();
        lg = legal();
        to = times_out();
        wc = write_cycle();
        be = to ? T + 1 : wc;
        bz = lg && c >= 1 && c <= be;
        ld = in_ld(c);
        cm = (c == wc);
        wrd = ld ? op.ld_rd : (cm ? op.rd : 5'd0);
        wd  = ld ? op.ld_data : (cm ? op.result : 32'd0);
        return {!bz, lg && c == 1, bz ? r : 3'd0, bz ? op.rs1 : 5'd0,
                bz ? op.rs2 : 5'd0, ld || cm, wrd, wd, cm ? op.flags : 5'd0,
                !lg && c == 1, to && c == T + 2, bz};
    endfunction

    function automatic op_t default_op();
        op_t o;
        o.rd = 5'd0; o.rs1 = 5'd0; o.rs2 = 5'd0;
        o.frm = 3'd0; o.fcsr = 3'd0; o.d = 0;
        o.result = 32'd0; o.flags = 5'd0;
        o.ld_s = 0; o.ld_n = 0; o.ld_rd = 5'd0; o.ld_data = 32'd0;
        o.stray = 1'b0;
        return o;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input int c);
        int  dc;
        bit  real_done;
        dc        = (op.d >= 0) ? 1 + op.d : T + 1;
        real_done = (op.d >= 0) && (c == 1 + op.d);
        req_valid = (c == 0);
        req_rd    = (c == 0) ? op.rd   : 5'($urandom);
        req_rs1   = (c == 0) ? op.rs1  : 5'($urandom);
        req_rs2   = (c == 0) ? op.rs2  : 5'($urandom);
        req_frm   = (c == 0) ? op.frm  : 3'($urandom);
        fcsr_frm  = (c == 0) ? op.fcsr : 3'($urandom);
        fpu_done  = real_done || (op.stray && (c == 0 || c > dc));
        fpu_result = real_done ? op.result : $urandom;
        fpu_flags  = real_done ? op.flags  : 5'($urandom);
        ld_wen    = in_ld(c);
        ld_rd     = ld_wen ? op.ld_rd   : 5'($urandom);
        ld_data   = ld_wen ? op.ld_data : $urandom;
    endtask

    task automatic quiet_inputs();
        req_valid = 1'b0;
        fpu_done  = 1'b0;
        ld_wen    = 1'b0;
    endtask

    task automatic announce(input string name);
        $display("op %-10s rd=%0d rs1=%0d rs2=%0d frm=%0d fcsr=%0d d=%0d ld=%0d+%0d",
                 name, op.rd, op.rs1, op.rs2, op.frm, op.fcsr, op.d, op.ld_s, op.ld_n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1; ld_wen = 1'b1; ld_rd = 5'd9; ld_data = 32'h12345678;
        fpu_done = 1'b1; req_frm = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== QUIET_VEC) $display("FAIL reset_hold cyc %0d: got %h want %h", i, obs, QUIET_VEC);
            else passes++;
        end
        quiet_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_VEC) $display("FAIL reset_release: got %h want %h", obs, IDLE_VEC);
        else passes++;
        $display("op reset     released");
    endtask

    task automatic test_basic();
        op = default_op();
        op.rd = 5'd3; op.rs1 = 5'd1; op.rs2 = 5'd2; op.frm = FRM_RNE;
        op.d = 2; op.result = 32'h3F800000; op.flags = 5'b00001;
        announce("basic");
        for (int c = 0; c <= last_cycle(); c++) begin
            drive(c); #1;
            checks++;
            if (obs !== model_out(c)) $display("FAIL basic cyc %0d: got %h want %h", c, obs, model_out(c));
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dynamic();
        logic [2:0] fc[2];
        fc[0] = FRM_RDN;
        fc[1] = 3'b101;
        for (int k = 0; k < 2; k++) begin
            op = default_op();
            op.rd = 5'd12; op.rs1 = 5'd4; op.rs2 = 5'd5;
            op.frm = FRM_DYN; op.fcsr = fc[k];
            op.d = 1; op.result = 32'hC0490FDB; op.flags = 5'b10000;
            announce("dynamic");
            for (int c = 0; c <= last_cycle(); c++) begin
                drive(c); #1;
                checks++;
                if (obs !== model_out(c)) $display("FAIL dynamic%0d cyc %0d: got %h want %h", k, c, obs, model_out(c));
                else passes++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad[2];
        bad[0] = 3'b101;
        bad[1] = 3'b110;
        for (int k = 0; k < 2; k++) begin
            op = default_op();
            op.rd = 5'd8; op.frm = bad[k]; op.d = 0; op.result = 32'h1; op.flags = 5'h1F;
            announce("illegal");
            for (int c = 0; c <= last_cycle(); c++) begin
                drive(c); #1;
                checks++;
                if (obs !== model_out(c)) $display("FAIL illegal%0d cyc %0d: got %h want %h", k, c, obs, model_out(c));
                else passes++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_collision();
        op = default_op();
        op.rd = 5'd3; op.rs1 = 5'd1; op.rs2 = 5'd2; op.frm = FRM_RTZ;
        op.d = 0; op.result = 32'h40490FDB; op.flags = 5'b00011;
        op.ld_s = 2; op.ld_n = 2; op.ld_rd = 5'd7; op.ld_data = 32'hDEADBEEF;
        op.stray = 1'b1;
        announce("collision");
        for (int c = 0; c <= last_cycle(); c++) begin
            drive(c); #1;
            checks++;
            if (obs !== model_out(c)) $display("FAIL collision cyc %0d: got %h want %h", c, obs, model_out(c));
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        op = default_op();
        op.rd = 5'd20; op.rs1 = 5'd21; op.rs2 = 5'd22; op.frm = FRM_RUP; op.d = -1;
        announce("timeout");
        for (int c = 0; c <= last_cycle(); c++) begin
            drive(c); #1;
            checks++;
            if (obs !== model_out(c)) $display("FAIL timeout cyc %0d: got %h want %h", c, obs, model_out(c));
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_done_in_start();
        op = default_op();
        op.rd = 5'd0; op.rs1 = 5'd30; op.rs2 = 5'd31; op.frm = FRM_RMM;
        op.d = 0; op.result = 32'h7F800000; op.flags = 5'b00100;
        announce("start_done");
        for (int c = 0; c <= last_cycle(); c++) begin
            drive(c); #1;
            checks++;
            if (obs !== model_out(c)) $display("FAIL done_in_start cyc %0d: got %h want %h", c, obs, model_out(c));
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_exec();
        op = default_op();
        op.rd = 5'd5; op.rs1 = 5'd6; op.rs2 = 5'd7; op.frm = FRM_RNE; op.d = -1;
        announce("rst_exec");
        for (int c = 0; c <= 2; c++) begin
            drive(c); #1;
            checks++;
            if (obs !== model_out(c)) $display("FAIL rst_exec cyc %0d: got %h want %h", c, obs, model_out(c));
            else passes++;
            @(posedge clk); #1;
        end
        quiet_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== QUIET_VEC) $display("FAIL rst_exec_hold: got %h want %h", obs, QUIET_VEC);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        fpu_done = 1'b1; fpu_result = 32'hCAFEF00D; fpu_flags = 5'h1F;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (obs !== IDLE_VEC) $display("FAIL rst_exec_after cyc %0d: got %h want %h", i, obs, IDLE_VEC);
            else passes++;
            @(posedge clk); #1;
            fpu_done = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            op = default_op();
            op.rd = 5'($urandom); op.rs1 = 5'($urandom); op.rs2 = 5'($urandom);
            op.frm = ($urandom_range(0, 3) == 0) ? FRM_DYN : 3'($urandom_range(0, 4));
            op.fcsr = 3'($urandom_range(0, 7));
            op.d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            op.result = $urandom; op.flags = 5'($urandom);
            op.ld_s = int'($urandom_range(0, 6)); op.ld_n = int'($urandom_range(0, 3));
            op.ld_rd = 5'($urandom); op.ld_data = $urandom;
            op.stray = 1'($urandom);
            announce("random");
            for (int c = 0; c <= last_cycle(); c++) begin
                drive(c); #1;
                checks++;
                if (obs !== model_out(c)) $display("FAIL random%0d cyc %0d: got %h want %h", n, c, obs, model_out(c));
                else passes++;
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dynamic();
        test_illegal();
        test_collision();
        test_timeout();
        test_done_in_start();
        test_reset_in_exec();
        test_random();
        quiet_inputs();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
